// File: rtl/inst_mem_ctrl.sv
// rtl/inst_mem_ctrl.sv - instruction fetch request controller: fetch handshake to one-outstanding bus read
// Covers redirect flushes, misaligned addresses and bus timeouts; every output is registered.
module inst_mem_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_mem_read_en,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_mem_ready,
    output logic              inst_fault,
    output logic              bus_req_valid,
    output logic [ADDR_W-1:0] bus_req_addr,
    input  logic              bus_req_ready,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    input  logic              bus_rsp_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DROP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inst_data_q;
    logic              ready_q;
    logic              fault_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              drop_q;
    logic              pending_q;
    logic              done_first_q;
    logic [7:0]        cnt_q;

    logic              drop_exit_d;
    logic              pending_d;
    logic [ADDR_W-1:0] pend_addr_d;
    logic              launch_d;
    logic [ADDR_W-1:0] launch_addr_d;
    logic [7:0]        cnt_d;

    // A read_en seen in the exit cycle of DROP still counts; a flush in that cycle cancels it.
    always_comb begin
        drop_exit_d   = (state_q == DROP) && (bus_rsp_valid || (cnt_q == TMO));
        pending_d     = !flush && (inst_mem_read_en || pending_q);
        pend_addr_d   = (inst_mem_read_en && !flush) ? inst_addr : addr_q;
        cnt_d         = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
        launch_d      = 1'b0;
        launch_addr_d = inst_addr;
        case (state_q)
            IDLE:    launch_d = inst_mem_read_en;
            DONE:    launch_d = !done_first_q && inst_mem_read_en && !flush;
            DROP: begin
                launch_d      = drop_exit_d && pending_d;
                launch_addr_d = pend_addr_d;
            end
            default: launch_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            inst_data_q  <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            pending_q    <= 1'b0;
            done_first_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            done_first_q <= 1'b0;
            case (state_q)
                REQ: begin
                    if (bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        drop_q      <= 1'b0;
                        state_q     <= (drop_q || flush) ? DROP : WAIT;
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (flush) begin
                        state_q <= bus_rsp_valid ? IDLE : DROP;
                    end else if (bus_rsp_valid) begin
                        state_q      <= DONE;
                        inst_data_q  <= bus_rsp_data;
                        fault_q      <= bus_rsp_err;
                        ready_q      <= 1'b1;
                        done_first_q <= 1'b1;
                    end else if (cnt_q == TMO) begin
                        state_q      <= DONE;
                        inst_data_q  <= NOP_INST;
                        fault_q      <= 1'b1;
                        ready_q      <= 1'b1;
                        done_first_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                DROP: begin
                    cnt_q     <= cnt_d;
                    addr_q    <= pend_addr_d;
                    pending_q <= pending_d;
                    if (drop_exit_d) begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Starting a new fetch overrides whatever the state branch chose above.
            if (launch_d) begin
                if (launch_addr_d[1:0] != 2'b00) begin
                    state_q      <= DONE;
                    inst_data_q  <= NOP_INST;
                    fault_q      <= 1'b1;
                    ready_q      <= 1'b1;
                    done_first_q <= 1'b1;
                end else begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                    req_addr_q  <= launch_addr_d;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            end
        end
    end

    assign inst_data      = inst_data_q;
    assign inst_mem_ready = ready_q;
    assign inst_fault     = fault_q;
    assign bus_req_valid  = req_valid_q;
    assign bus_req_addr   = req_addr_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb/tb_inst_mem_ctrl.sv - self-checking bench for inst_mem_ctrl
module tb_inst_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_mem_read_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] inst_data;
    logic        inst_mem_ready;
    logic        inst_fault;
    logic        bus_req_valid;
    logic [31:0] bus_req_addr;
    logic        bus_req_ready = 1'b0;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_data = '0;
    logic        bus_rsp_err = 1'b0;

    localparam logic [31:0] NOP = 32'h00000013;

    inst_mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .inst_mem_read_en (inst_mem_read_en),
        .inst_addr        (inst_addr),
        .flush            (flush),
        .inst_data        (inst_data),
        .inst_mem_ready   (inst_mem_ready),
        .inst_fault       (inst_fault),
        .bus_req_valid    (bus_req_valid),
        .bus_req_addr     (bus_req_addr),
        .bus_req_ready    (bus_req_ready),
        .bus_rsp_valid    (bus_rsp_valid),
        .bus_rsp_data     (bus_rsp_data),
        .bus_rsp_err      (bus_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rsp_data;
        logic        rsp_err;
        logic        bus;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_ready  = 0;
    int n_orphan = 0;
    logic [32:0] sb_q[$];

    always @(negedge clk) begin
        if (bus_req_valid && bus_req_ready) n_accept++;
        if (inst_mem_ready) n_ready++;
        if (inst_mem_ready && inst_data == 32'hDEADBEEF) n_orphan++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] d, input logic f);
        sb_q.push_back({f, d});
    endtask

    task automatic sb_pop_check(input string name);
        logic [32:0] e;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_data"}, inst_data, e[31:0]);
            check({name, "_fault"}, inst_fault, e[32]);
        end
    endtask

    // Expects bus_req_valid up now; accepts, answers one cycle later, checks the word.
    task automatic complete_bus(input logic [31:0] a, input logic [31:0] d, input logic err);
        check("req_valid", bus_req_valid, 1);
        check("req_addr", bus_req_addr, a);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("req_released", bus_req_valid, 0);
        check("ready_before_rsp", inst_mem_ready, 0);
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = d;
        bus_rsp_err   = err;
        tick();
        bus_rsp_valid = 1'b0;
        check("ready_after_rsp", inst_mem_ready, 1);
        sb_pop_check("rsp");
    endtask

    task automatic fetch_vec(input vec_t v);
        sb_push(v.exp_data, v.exp_fault);
        inst_mem_read_en = 1'b1;
        inst_addr        = v.addr;
        tick();
        inst_mem_read_en = 1'b0;
        if (v.bus) begin
            complete_bus(v.addr, v.rsp_data, v.rsp_err);
        end else begin
            check("misaligned_no_req", bus_req_valid, 0);
            check("misaligned_ready", inst_mem_ready, 1);
            sb_pop_check("misaligned");
        end
    endtask

    task automatic flush_to_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready_low", inst_mem_ready, 0);
    endtask

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, rc0, oc0, n;
        logic [31:0] held;
        vecs[0] = '{addr:32'h00001000, rsp_data:32'h00500093, rsp_err:1'b0, bus:1'b1, exp_data:32'h00500093, exp_fault:1'b0};
        vecs[1] = '{addr:32'h00001002, rsp_data:32'h0,        rsp_err:1'b0, bus:1'b0, exp_data:NOP,          exp_fault:1'b1};
        vecs[2] = '{addr:32'h00002004, rsp_data:32'hABCD1234, rsp_err:1'b1, bus:1'b1, exp_data:32'hABCD1234, exp_fault:1'b1};
        vecs[3] = '{addr:32'h00000003, rsp_data:32'h0,        rsp_err:1'b0, bus:1'b0, exp_data:NOP,          exp_fault:1'b1};
        vecs[4] = '{addr:32'hFFFFFFFC, rsp_data:32'h12345678, rsp_err:1'b0, bus:1'b1, exp_data:32'h12345678, exp_fault:1'b0};
        vecs[5] = '{addr:32'h00001001, rsp_data:32'h0,        rsp_err:1'b0, bus:1'b0, exp_data:NOP,          exp_fault:1'b1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", inst_mem_ready, 0);
        check("rst_data", inst_data, 0);
        check("rst_fault", inst_fault, 0);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_req_addr", bus_req_addr, 0);

        // Vector table: each fetch from IDLE, word held with read_en low, then flushed.
        for (int i = 0; i < 6; i++) begin
            fetch_vec(vecs[i]);
            held = inst_data;
            for (int k = 0; k < 5; k++) tick();
            check("hold_ready", inst_mem_ready, 1);
            check("hold_data", inst_data, held);
            flush_to_idle();
        end

        // Back-to-back: read_en in first DONE cycle is ignored, in second it consumes.
        fetch_vec(vecs[0]);
        acc0 = n_accept;
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00001008;
        tick();
        inst_mem_read_en = 1'b0;
        check("first_done_ignored_ready", inst_mem_ready, 1);
        check("first_done_ignored_req", bus_req_valid, 0);
        tick();
        check("first_done_no_accept", n_accept - acc0, 0);
        sb_push(32'h00600113, 1'b0);
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00001004;
        tick();
        inst_mem_read_en = 1'b0;
        check("consume_ready_low", inst_mem_ready, 0);
        complete_bus(32'h00001004, 32'h00600113, 1'b0);
        check("b2b_one_accept", n_accept - acc0, 1);
        flush_to_idle();

        // Flush in WAIT, new fetch during DROP, orphan response discarded.
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00003000;
        tick();
        inst_mem_read_en = 1'b0;
        bus_req_ready    = 1'b1;
        tick();
        bus_req_ready    = 1'b0;
        oc0 = n_orphan;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00002000;
        tick();
        inst_mem_read_en = 1'b0;
        tick();
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 32'hDEADBEEF;
        tick();
        bus_rsp_valid = 1'b0;
        check("drop_ready_low", inst_mem_ready, 0);
        sb_push(32'h00000517, 1'b0);
        complete_bus(32'h00002000, 32'h00000517, 1'b0);
        check("orphan_never_seen", n_orphan - oc0, 0);
        flush_to_idle();

        // Request stall with flush: request held, then DROP, then IDLE without ready.
        rc0 = n_ready;
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00004000;
        tick();
        inst_mem_read_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", bus_req_valid, 1);
            check("stall_addr", bus_req_addr, 32'h00004000);
            flush = (i == 3);
            tick();
        end
        flush = 1'b0;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("drop_req_released", bus_req_valid, 0);
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 32'hCAFEF00D;
        tick();
        bus_rsp_valid = 1'b0;
        tick();
        check("stall_ready_never", n_ready - rc0, 0);
        check("stall_idle_no_req", bus_req_valid, 0);
        fetch_vec(vecs[2]);
        flush_to_idle();

        // Timeout in WAIT.
        sb_push(NOP, 1'b1);
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00005000;
        tick();
        inst_mem_read_en = 1'b0;
        bus_req_ready    = 1'b1;
        tick();
        bus_req_ready    = 1'b0;
        n = 0;
        while (!inst_mem_ready && n < 400) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 256);
        sb_pop_check("timeout");
        flush_to_idle();

        // Reset mid-WAIT; late response ignored.
        inst_mem_read_en = 1'b1;
        inst_addr        = 32'h00006000;
        tick();
        inst_mem_read_en = 1'b0;
        bus_req_ready    = 1'b1;
        tick();
        bus_req_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", inst_mem_ready, 0);
        check("midrst_data", inst_data, 0);
        check("midrst_fault", inst_fault, 0);
        check("midrst_req_valid", bus_req_valid, 0);
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 32'h77777777;
        tick();
        bus_rsp_valid = 1'b0;
        tick();
        check("late_rsp_ready", inst_mem_ready, 0);
        check("late_rsp_data", inst_data, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
